// File: rtl/mdu_hilo_unit_pkg.sv
// Shared types for the multiply/divide unit: operation codes, FSM states and default width.
// MDU_MADD_EN widens the op code to make room for the multiply-accumulate operations.
package mdu_pkg;

  localparam int MDU_XLEN = 32;

`ifdef MDU_MADD_EN
  localparam int MDU_OP_W = 4;
`else
  localparam int MDU_OP_W = 3;
`endif

  typedef enum logic [MDU_OP_W-1:0] {
    NOP   = MDU_OP_W'(0),
    MULT  = MDU_OP_W'(1),
    MULTU = MDU_OP_W'(2),
    DIV   = MDU_OP_W'(3),
    DIVU  = MDU_OP_W'(4),
    MTHI  = MDU_OP_W'(5),
    MTLO  = MDU_OP_W'(6)
`ifdef MDU_MADD_EN
    ,
    MADD  = MDU_OP_W'(7),
    MADDU = MDU_OP_W'(8),
    MSUB  = MDU_OP_W'(9),
    MSUBU = MDU_OP_W'(10)
`endif
  } mdu_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3
`ifdef MDU_MADD_EN
    ,
    S_ACC  = 3'd4
`endif
  } mdu_state_e;

  function automatic logic op_signed(input mdu_op_e op);
    logic s;
    s = (op == MULT) || (op == DIV);
`ifdef MDU_MADD_EN
    s = s || (op == MADD) || (op == MSUB);
`endif
    return s;
  endfunction

endpackage

// File: rtl/mdu_hilo_unit_if.sv
// Request channel of the multiply/divide unit: valid/ready handshake plus op and operands.
interface mdu_hilo_unit_if
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
);
  logic            req_valid;
  logic            req_ready;
  mdu_op_e         req_op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;

  modport master (output req_valid, output req_op, output src_a, output src_b, input req_ready);
  modport slave  (input req_valid, input req_op, input src_a, input src_b, output req_ready);
endinterface

// File: rtl/mdu_hilo_unit_divider.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, XLEN cycles after i_start.
// o_done marks the final iteration; o_quo/o_rem hold the result from the following cycle on.
module mdu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quo,
  output logic [XLEN-1:0] o_rem
);
  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_div;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_trial;

  // The dividend shifts out of r_quo into the partial remainder while quotient bits shift in.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_div};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_div <= '0;
    end else if (i_abort) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= CW'(XLEN);
      r_quo <= i_dividend;
      r_rem <= '0;
      r_div <= i_divisor;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
      if (w_trial[XLEN]) begin
        r_rem <= w_shift[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b0};
      end else begin
        r_rem <= w_trial[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b1};
      end
    end
  end

  assign o_done = (r_cnt == CW'(1));
  assign o_quo  = r_quo;
  assign o_rem  = r_rem;
endmodule

// File: rtl/mdu_hilo_unit.sv
// Multiply/divide unit owning HI/LO: timed multiply, iterative divide, flush abort, HI/LO interlock.
// Optional feature macro: MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU with an extra accumulate cycle.
module mdu_hilo_unit
  import mdu_pkg::*;
#(
  parameter int XLEN    = MDU_XLEN,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  mdu_hilo_unit_if.slave  req,
  input  logic            flush_i,
  input  logic            hilo_rd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic            busy_o,
  output logic            stall_o,
  output logic            commit_o
);
  localparam int CNT_W = 3;

  mdu_state_e        r_state;
  mdu_state_e        w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   w_hi_next;
  logic [XLEN-1:0]   w_lo_next;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic              r_signed;
  logic              r_divz;
`ifdef MDU_MADD_EN
  logic              r_acc;
  logic              r_sub;
`endif
  logic              w_commit;

  logic              w_accept;
  logic              w_is_div;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_div_start;
  logic              w_div_abort;
  logic              w_div_done;
  logic [XLEN-1:0]   w_div_quo;
  logic [XLEN-1:0]   w_div_rem;
  logic [XLEN-1:0]   w_q_fix;
  logic [XLEN-1:0]   w_r_fix;
  logic [2*XLEN-1:0] w_a_ext;
  logic [2*XLEN-1:0] w_b_ext;
  logic [2*XLEN-1:0] w_prod;

  assign req.req_ready = (r_state == S_IDLE);
  assign w_accept      = req.req_valid & req.req_ready & ~flush_i;
  assign w_is_div      = (req.req_op == DIV) || (req.req_op == DIVU);

  assign w_a_neg     = op_signed(req.req_op) & req.src_a[XLEN-1];
  assign w_b_neg     = op_signed(req.req_op) & req.src_b[XLEN-1];
  assign w_a_mag     = w_a_neg ? -req.src_a : req.src_a;
  assign w_b_mag     = w_b_neg ? -req.src_b : req.src_b;
  assign w_div_start = w_accept & w_is_div & (req.src_b != '0);
  assign w_div_abort = (r_state == S_DIV) & flush_i;

  mdu_divider #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_abort    (w_div_abort),
    .i_dividend (w_a_mag),
    .i_divisor  (w_b_mag),
    .o_done     (w_div_done),
    .o_quo      (w_div_quo),
    .o_rem      (w_div_rem)
  );

  // Sign-extending to 2*XLEN lets one unsigned multiplier serve both signed and unsigned ops.
  assign w_a_ext = {{XLEN{r_signed & r_a[XLEN-1]}}, r_a};
  assign w_b_ext = {{XLEN{r_signed & r_b[XLEN-1]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_q_fix = (r_signed & (r_a[XLEN-1] ^ r_b[XLEN-1])) ? -w_div_quo : w_div_quo;
  assign w_r_fix = (r_signed & r_a[XLEN-1]) ? -w_div_rem : w_div_rem;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_hi_next    = r_hi;
    w_lo_next    = r_lo;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (req.req_op)
            MULT, MULTU: begin
              w_state_next = S_MUL;
              w_cnt_next   = CNT_W'(MUL_LAT - 1);
            end
`ifdef MDU_MADD_EN
            MADD, MADDU, MSUB, MSUBU: begin
              w_state_next = S_MUL;
              w_cnt_next   = CNT_W'(MUL_LAT - 1);
            end
`endif
            DIV, DIVU:   w_state_next = (req.src_b == '0) ? S_FIX : S_DIV;
            MTHI:        w_hi_next = req.src_a;
            MTLO:        w_lo_next = req.src_a;
            default:     ;
          endcase
        end
      end
      S_MUL: begin
        if (r_cnt != '0) begin
          if (flush_i) w_state_next = S_IDLE;
          else         w_cnt_next   = r_cnt - CNT_W'(1);
        end
`ifdef MDU_MADD_EN
        else if (r_acc) begin
          w_state_next = flush_i ? S_IDLE : S_ACC;
        end
`endif
        else begin
          // Commit cycle: a flush here belongs to a younger instruction and is ignored.
          w_commit               = 1'b1;
          {w_hi_next, w_lo_next} = w_prod;
          w_state_next           = S_IDLE;
        end
      end
      S_DIV: begin
        if (flush_i)         w_state_next = S_IDLE;
        else if (w_div_done) w_state_next = S_FIX;
      end
      S_FIX: begin
        w_commit     = 1'b1;
        w_state_next = S_IDLE;
        if (r_divz) begin
          w_hi_next = r_a;
          w_lo_next = '1;
        end else begin
          w_hi_next = w_r_fix;
          w_lo_next = w_q_fix;
        end
      end
`ifdef MDU_MADD_EN
      S_ACC: begin
        w_commit               = 1'b1;
        w_state_next           = S_IDLE;
        {w_hi_next, w_lo_next} = r_sub ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_divz   <= 1'b0;
`ifdef MDU_MADD_EN
      r_acc    <= 1'b0;
      r_sub    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_hi    <= w_hi_next;
      r_lo    <= w_lo_next;
      if (w_accept) begin
        r_a      <= req.src_a;
        r_b      <= req.src_b;
        r_signed <= op_signed(req.req_op);
        r_divz   <= (req.src_b == '0);
`ifdef MDU_MADD_EN
        r_acc    <= (req.req_op == MADD) || (req.req_op == MADDU) ||
                    (req.req_op == MSUB) || (req.req_op == MSUBU);
        r_sub    <= (req.req_op == MSUB) || (req.req_op == MSUBU);
`endif
      end
    end
  end

  assign hi_o     = r_hi;
  assign lo_o     = r_lo;
  assign busy_o   = (r_state != S_IDLE);
  assign stall_o  = busy_o & hilo_rd_i;
  assign commit_o = w_commit;
endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Directed bench for mdu_hilo_unit (XLEN=32, MUL_LAT=3) with hand-computed HI/LO results.
module tb_mdu_hilo_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        hilo_rd_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;
  logic        stall_o;
  logic        commit_o;

  int total = 0;
  int bad   = 0;

  mdu_hilo_unit_if #(.XLEN(32)) req_if ();

  mdu_hilo_unit #(.XLEN(32), .MUL_LAT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req_if),
    .flush_i   (flush_i),
    .hilo_rd_i (hilo_rd_i),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .busy_o    (busy_o),
    .stall_o   (stall_o),
    .commit_o  (commit_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
    req_if.req_valid = 1'b1;
    req_if.req_op    = op;
    req_if.src_a     = a;
    req_if.src_b     = b;
    tick();
    req_if.req_valid = 1'b0;
    req_if.req_op    = NOP;
    $display("txn op=%s a=%08h b=%08h", op.name(), a, b);
  endtask

  // Returns the commit cycle index counted from the first cycle after accept (bounded).
  task automatic wait_commit(output int n, output logic stall_all);
    n = 1;
    stall_all = 1'b1;
    while (commit_o !== 1'b1 && n < 100) begin
      stall_all &= stall_o;
      tick();
      n++;
    end
    stall_all &= stall_o;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic st;
    int   commits;

    rst              = 1'b1;
    flush_i          = 1'b0;
    hilo_rd_i        = 1'b0;
    req_if.req_valid = 1'b0;
    req_if.req_op    = NOP;
    req_if.src_a     = '0;
    req_if.src_b     = '0;
    tick();
    tick();
    chk("rst_hi", 64'(hi_o), 64'h0);
    chk("rst_lo", 64'(lo_o), 64'h0);
    chk("rst_busy", 64'(busy_o), 64'h0);
    chk("rst_commit", 64'(commit_o), 64'h0);
    chk("rst_ready", 64'(req_if.req_ready), 64'h1);
    rst = 1'b0;
    tick();

    // MULT -2 * 3
    issue(MULT, 32'hFFFFFFFE, 32'd3);
    chk("mult_busy", 64'(busy_o), 64'h1);
    wait_commit(n, st);
    chk("mult_lat", 64'(n), 64'd3);
    chk("mult_no_bypass", 64'(hi_o), 64'h0);
    tick();
    chk("mult_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFA);
    chk("mult_ready_after", 64'(req_if.req_ready), 64'h1);
    chk("mult_commit_pulse", 64'(commit_o), 64'h0);

    // MULTU back-to-back
    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_commit(n, st);
    chk("multu_lat", 64'(n), 64'd3);
    tick();
    chk("multu_hilo", {hi_o, lo_o}, 64'hFFFFFFFE_00000001);

    // DIV -7 / 2 with an HI/LO reader waiting
    hilo_rd_i = 1'b1;
    chk("div_stall_idle", 64'(stall_o), 64'h0);
    issue(DIV, 32'hFFFFFFF9, 32'd2);
    wait_commit(n, st);
    chk("div_lat", 64'(n), 64'd33);
    chk("div_stall_all", 64'(st), 64'h1);
    tick();
    chk("div_stall_clear", 64'(stall_o), 64'h0);
    chk("div_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFD);
    hilo_rd_i = 1'b0;

    // DIV 7 / -2 -> q=-3, r=1
    issue(DIV, 32'd7, 32'hFFFFFFFE);
    wait_commit(n, st);
    chk("div2_lat", 64'(n), 64'd33);
    tick();
    chk("div2_hilo", {hi_o, lo_o}, 64'h00000001_FFFFFFFD);

    // Signed overflow: most-negative / -1
    issue(DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_commit(n, st);
    tick();
    chk("divovf_hilo", {hi_o, lo_o}, 64'h00000000_80000000);

    // DIVU by zero
    issue(DIVU, 32'd100, 32'd0);
    wait_commit(n, st);
    chk("divz_lat", 64'(n), 64'd1);
    tick();
    chk("divz_hilo", {hi_o, lo_o}, 64'h00000064_FFFFFFFF);

    // DIV 50 / 7 flushed at cycle 10
    issue(DIV, 32'd50, 32'd7);
    repeat (9) tick();
    chk("flush_busy_before", 64'(busy_o), 64'h1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_busy_after", 64'(busy_o), 64'h0);
    commits = 0;
    for (int i = 0; i < 40; i++) begin
      if (commit_o === 1'b1) commits++;
      tick();
    end
    chk("flush_no_commit", 64'(commits), 64'd0);
    chk("flush_hilo_kept", {hi_o, lo_o}, 64'h00000064_FFFFFFFF);

    // Flush together with a request in IDLE drops the request
    req_if.req_valid = 1'b1;
    req_if.req_op    = MTHI;
    req_if.src_a     = 32'hDEAD;
    flush_i          = 1'b1;
    tick();
    req_if.req_valid = 1'b0;
    flush_i          = 1'b0;
    $display("txn op=MTHI (flushed) a=0000dead");
    chk("drop_hi", 64'(hi_o), 64'h64);
    chk("drop_busy", 64'(busy_o), 64'h0);

    // Flush in the commit cycle does not cancel the commit
    issue(MULTU, 32'd5, 32'd6);
    wait_commit(n, st);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_commit_hilo", {hi_o, lo_o}, 64'h00000000_0000001E);

    // MTHI then MTLO on consecutive cycles
    req_if.req_valid = 1'b1;
    req_if.req_op    = MTHI;
    req_if.src_a     = 32'h1234;
    tick();
    chk("mthi_hi", 64'(hi_o), 64'h1234);
    chk("mthi_busy", 64'(busy_o), 64'h0);
    req_if.req_op    = MTLO;
    req_if.src_a     = 32'h5678;
    tick();
    req_if.req_valid = 1'b0;
    req_if.req_op    = NOP;
    $display("txn op=MTHI/MTLO a=00001234/00005678");
    chk("mtlo_hilo", {hi_o, lo_o}, 64'h00001234_00005678);

    // Reset during a MULT
    issue(MULT, 32'd3, 32'd4);
    rst = 1'b1;
    tick();
    chk("midrst_hilo", {hi_o, lo_o}, 64'h0);
    chk("midrst_ready", 64'(req_if.req_ready), 64'h1);
    chk("midrst_busy", 64'(busy_o), 64'h0);
    rst = 1'b0;
    repeat (5) tick();
    chk("midrst_no_commit", {hi_o, lo_o}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
